serial_parity_rx: RTL
=====================

// Module: serial_parity_rx
// PURPOSE
//   Receive end of the 16-bit serial word link. Deserialises one framed word
//   from a single idle-high line and recomputes its XOR parity from the
//   received data bits. Presents the word and error flags to the CPU-side
//   register file. The mating block is the link's parity-generating transmitter.
// PARAMETERS
//   DATA_WIDTH    16  data bits per frame, sent LSB first
//   CLKS_PER_BIT  4   clk cycles per serial bit; must be even and >= 2
//   PARITY_ODD    0   0: even parity (XOR of data^parity == 0); 1: odd parity
// PORTS
//   clk         in   1           single system clock, rising edge
//   rst_n       in   1           asynchronous assert, active-low reset
//   rx_serial   in   1           serial line, idle high, asynchronous to clk
//   data        out  DATA_WIDTH  last received word
//   data_valid  out  1           one-cycle pulse: data/flags just updated
//   parity_err  out  1           last frame parity mismatch
//   frame_err   out  1           last frame stop bit sampled 0
//   busy        out  1           high while not in IDLE
// BEHAVIOUR
//   - Reset is asynchronous and active-low. While rst_n=0, the block is in IDLE.
//     data=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//     Both synchroniser flops are preset to 1.
//     Asserting rst_n mid-frame aborts the frame. No data_valid is issued for it.
//   - rx_serial passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//   - Frame: start(0), DATA_WIDTH data bits LSB first, parity, stop(1).
//     Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
//   - Bit-cycle counter cnt counts up from 0. A bit is sampled when cnt reaches
//     its target; cnt then clears to 0.
//   - FSM states:
//     IDLE:   rx_s==0 -> START, cnt=0.
//     START:  at cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
//             rx_s==1 -> IDLE (glitch rejected, no flags change).
//             rx_s==0 -> DATA, bit index=0.
//     DATA:   at cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB
//             side, fold it into running XOR parity, and increment the index.
//             After bit DATA_WIDTH-1 -> PARITY.
//     PARITY: at cnt==CLKS_PER_BIT-1, XOR rx_s into the running parity.
//             Expected result is PARITY_ODD -> STOP.
//     STOP:   at cnt==CLKS_PER_BIT-1, on the following edge:
//             - data <= shift register; data_valid <= 1 for exactly one cycle.
//             - parity_err <= (running parity != PARITY_ODD).
//             - frame_err <= ~rx_s.
//             -> IDLE.
//   - Error flags are captured, not sticky. They hold until the next data_valid.
//   - A word is delivered even when either error flag is set.
//   - Return to IDLE happens at mid stop bit, so a start bit directly after the
//     stop bit (back-to-back frames) is caught.
//   - If the stop bit is 0 (line still low), IDLE sees rx_s==0 and starts a new
//     frame immediately (break behaviour). This is intended.
//   - Latency: data_valid rises 2 (sync) + 1 cycles after the stop-bit
//     mid-sample instant on rx_serial.
//   - busy = (state != IDLE).
// TESTING
//   (CLKS_PER_BIT=4, DATA_WIDTH=16, PARITY_ODD=0)
//   1. Send 16'hA5C3, parity bit 0, stop 1.
//      -> one data_valid pulse, data=16'hA5C3, parity_err=0, frame_err=0.
//   2. Send 16'h0001 with parity bit 0 (wrong; correct is 1).
//      -> data=16'h0001, parity_err=1, frame_err=0.
//   3. Send 16'hFFFF, correct parity bit 0, stop bit driven 0.
//      -> data=16'hFFFF, frame_err=1, parity_err=0; then busy stays 1 (break).
//   4. Pulse rx_serial low for 1 cycle while idle.
//      -> busy rises then falls within 4 cycles; no data_valid; flags unchanged.
//   5. Send 16'h1234 then 16'h8000 back-to-back, second start bit directly after
//      the first stop bit.
//      -> two data_valid pulses 76 cycles apart, correct data, no errors.
//   6. Drop rst_n for 1 cycle mid data bits of 16'h5555.
//      -> all outputs 0 at once, no data_valid; the next clean frame 16'h00FF is
//      received correctly.

Source files
------------

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - framed serial word receiver with XOR parity and stop-bit checking
// Line is idle high; frame is start(0), data LSB first, parity, stop(1).

module serial_parity_rx #(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic                  rx_meta_q;
    logic                  rx_s_q;
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  busy_q;

    // Preset to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            par_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        par_q   <= par_q ^ rx_s_q;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_q <= PARITY;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        par_q   <= par_q ^ rx_s_q;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be caught in IDLE.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        perr_q  <= (par_q != PARITY_ODD);
                        ferr_q  <= ~rx_s_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
